// File: rtl/mac_mult_block_pipe.sv
// mac_mult_block_pipe: two-stage lane multiplier (SINGLE/DUAL/QUAD) with valid/ready flow control.
// Optional stage-2 accumulator with acc_en/acc_clr ports is built when MAC_MULT_ACC_EN is defined.
module mac_mult_block_pipe #(
  parameter int MIN_WIDTH = 8,
  parameter int ACC_GUARD = 8,
  localparam int INT_WIDTH = 5 * MIN_WIDTH,
  localparam int ACC_WIDTH = INT_WIDTH + ACC_GUARD,
`ifdef MAC_MULT_ACC_EN
  localparam int C_WIDTH = ACC_WIDTH
`else
  localparam int C_WIDTH = ACC_WIDTH - ACC_GUARD
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*MIN_WIDTH-1:0] A,
  input  logic [MIN_WIDTH-1:0]   B3,
  input  logic [1:0]             cfg,
`ifdef MAC_MULT_ACC_EN
  input  logic                   acc_en,
  input  logic                   acc_clr,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [C_WIDTH-1:0]     C
);

  logic                   ready_q;
  logic                   advance_s;
  logic                   s1_valid_q;
  logic [1:0]             s1_cfg_q;
  logic [2*MIN_WIDTH-1:0] p_d [4];
  logic [2*MIN_WIDTH-1:0] p_q [4];
  logic [INT_WIDTH-1:0]   sum_s;
  logic                   out_valid_q;
  logic [C_WIDTH-1:0]     c_d;
  logic [C_WIDTH-1:0]     c_q;
`ifdef MAC_MULT_ACC_EN
  logic                   s1_acc_en_q;
  logic                   s1_acc_clr_q;
  logic [ACC_WIDTH-1:0]   acc_q;
  logic [ACC_WIDTH-1:0]   acc_d;
`endif

  // Holds in_ready low during reset; the pipeline may advance from the first edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_q <= 1'b0;
    else      ready_q <= 1'b1;
  end

  assign advance_s = en & ready_q & (~out_valid_q | out_ready);
  assign in_ready  = advance_s;
  assign out_valid = out_valid_q;
  assign C         = c_q;

  // Unsigned lane partial products Ai*B3.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      p_d[i] = {{MIN_WIDTH{1'b0}}, A[i*MIN_WIDTH +: MIN_WIDTH]} * {{MIN_WIDTH{1'b0}}, B3};
    end
  end

  // Stage 1: partial products plus the per-transaction controls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_cfg_q   <= 2'b00;
      for (int i = 0; i < 4; i++) p_q[i] <= '0;
`ifdef MAC_MULT_ACC_EN
      s1_acc_en_q  <= 1'b0;
      s1_acc_clr_q <= 1'b0;
`endif
    end else if (advance_s) begin
      s1_valid_q <= in_valid;
      s1_cfg_q   <= cfg;
      for (int i = 0; i < 4; i++) p_q[i] <= p_d[i];
`ifdef MAC_MULT_ACC_EN
      s1_acc_en_q  <= acc_en;
      s1_acc_clr_q <= acc_clr;
`endif
    end
  end

  // Mode-dependent combination of the registered partial products.
  always_comb begin
    sum_s = '0;
    case (s1_cfg_q)
      2'b00:   sum_s = INT_WIDTH'(p_q[3]);
      2'b01:   sum_s = INT_WIDTH'(p_q[2]) + (INT_WIDTH'(p_q[3]) << MIN_WIDTH);
      2'b10:   sum_s = INT_WIDTH'(p_q[0])
                     + (INT_WIDTH'(p_q[1]) << MIN_WIDTH)
                     + (INT_WIDTH'(p_q[2]) << (2*MIN_WIDTH))
                     + (INT_WIDTH'(p_q[3]) << (3*MIN_WIDTH));
      default: sum_s = '0;
    endcase
  end

`ifdef MAC_MULT_ACC_EN
  // Accumulator next state; bubbles leave it untouched.
  always_comb begin
    acc_d = acc_q;
    c_d   = C_WIDTH'(sum_s);
    if (s1_valid_q) begin
      acc_d = (s1_acc_clr_q ? {ACC_WIDTH{1'b0}} : acc_q)
            + (s1_acc_en_q ? ACC_WIDTH'(sum_s) : {ACC_WIDTH{1'b0}});
      if (s1_acc_en_q) c_d = acc_d;
      else             c_d = C_WIDTH'(sum_s);
    end else begin
      acc_d = acc_q;
      c_d   = C_WIDTH'(sum_s);
    end
  end

  // Accumulator register, wraps modulo 2^ACC_WIDTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           acc_q <= '0;
    else if (advance_s) acc_q <= acc_d;
  end
`else
  assign c_d = sum_s;
`endif

  // Stage 2: result register and output valid; C keeps its value across bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      c_q         <= '0;
    end else if (advance_s) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) c_q <= c_d;
    end
  end

endmodule

// File: tb/tb_mac_mult_block_pipe.sv
// Scoreboard bench for mac_mult_block_pipe: directed vectors push expected results,
// a negedge monitor pops and compares whenever an output is consumed.
module tb_mac_mult_block_pipe;

  localparam int W = 8;
`ifdef MAC_MULT_ACC_EN
  localparam int CW = 5*W + 8;
`else
  localparam int CW = 5*W;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          in_valid;
  logic          in_ready;
  logic [4*W-1:0] A;
  logic [W-1:0]  B3;
  logic [1:0]    cfg;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] C;
`ifdef MAC_MULT_ACC_EN
  logic          acc_en;
  logic          acc_clr;
`endif

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [CW-1:0] exp_q[$];
  logic          hold_v = 1'b0;
  logic [CW-1:0] hold_c;

  mac_mult_block_pipe #(.MIN_WIDTH(W), .ACC_GUARD(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B3       (B3),
    .cfg      (cfg),
`ifdef MAC_MULT_ACC_EN
    .acc_en   (acc_en),
    .acc_clr  (acc_clr),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .C        (C)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a result is consumed when out_valid & out_ready while the block is enabled
  // (with en low the block is frozen and the same result stays presented).
  always @(negedge clk) begin
    if (rst) begin
      if (hold_v) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_C", 64'(C), 64'(hold_c));
      end
      if (out_valid && out_ready && en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got C=0x%0h, expected no output", C);
        end else begin
          check("result", 64'(C), 64'(exp_q.pop_front()));
        end
      end
      hold_v = out_valid && !(out_ready && en);
      hold_c = C;
    end else begin
      hold_v = 1'b0;
    end
  end

  task automatic send(input logic [1:0] c, input logic [31:0] a, input logic [7:0] b,
                      input logic [CW-1:0] e);
    int budget = 50;
    bit done   = 1'b0;
    cfg = c; A = a; B3 = b; in_valid = 1'b1;
    while (!done && budget > 0) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        done = 1'b1;
      end else begin
        budget--;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected a transfer");
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t0;
    rst = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    cfg = 2'b00; A = '0; B3 = '0;
`ifdef MAC_MULT_ACC_EN
    acc_en = 1'b0; acc_clr = 1'b0;
`endif
    #2;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_C", 64'(C), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check("in_ready_before_edge", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    check("in_ready_after_edge", 64'(in_ready), 64'd1);

    // SINGLE latency: result visible after the second edge counting the transfer edge.
    send(2'b00, 32'hFF00_0000, 8'hFF, 40'h0_0000_FE01);
    check("lat_cycle1_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_cycle2_valid", 64'(out_valid), 64'd1);
    check("lat_cycle2_C", 64'(C), 64'h0_0000_FE01);
    idle(2);

    // Back-to-back stream, one transfer per cycle.
    t0 = $time;
    send(2'b01, 32'h1234_0000, 8'h10, 40'h00_0001_2340);
    send(2'b10, 32'h1234_5678, 8'h02, 40'h00_2468_ACF0);
    send(2'b11, 32'hFFFF_FFFF, 8'hFF, 40'h0);
    send(2'b10, 32'hFFFF_FFFF, 8'hFF, 40'hFE_FFFF_FF01);
    send(2'b01, 32'hFFFF_ABCD, 8'hFF, 40'h00_00FE_FF01);
    send(2'b00, 32'h03AA_BBCC, 8'h05, 40'h0F);
    send(2'b00, 32'hFFFF_FFFF, 8'h00, 40'h0);
    check("throughput_cycles", 64'(($time - t0) / 10), 64'd7);
    idle(4);

    // Backpressure: out_ready low for 5 cycles while 4 transfers are offered.
    out_ready = 1'b0;
    fork
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_C", 64'(C), 64'd7);
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join_none
    send(2'b10, 32'h0000_0001, 8'h07, 40'h7);
    send(2'b10, 32'h0100_0000, 8'h03, 40'h300_0000);
    send(2'b01, 32'h0002_0000, 8'h80, 40'h100);
    send(2'b00, 32'h8000_0000, 8'h80, 40'h4000);
    idle(5);

    // en low for 3 cycles mid-stream.
    fork
      begin
        repeat (3) @(posedge clk);
        #1 en = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("en_low_in_ready", 64'(in_ready), 64'd0);
          @(posedge clk);
        end
        #1 en = 1'b1;
      end
    join_none
    send(2'b00, 32'h0100_0000, 8'h11, 40'h11);
    send(2'b00, 32'h0200_0000, 8'h11, 40'h22);
    send(2'b00, 32'h0300_0000, 8'h11, 40'h33);
    send(2'b00, 32'h0400_0000, 8'h11, 40'h44);
    send(2'b00, 32'h0500_0000, 8'h11, 40'h55);
    send(2'b00, 32'h0600_0000, 8'h11, 40'h66);
    idle(5);

    // Reset with two transactions in flight: both are discarded.
    send(2'b10, 32'h0000_0001, 8'h10, 40'h10);
    send(2'b10, 32'h0000_0002, 8'h10, 40'h20);
    #1 rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_C", 64'(C), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle(6);
    check("no_stale_valid", 64'(out_valid), 64'd0);
    send(2'b00, 32'h0200_0000, 8'h02, 40'h4);
    idle(3);

`ifdef MAC_MULT_ACC_EN
    // Accumulator: 15, 30, 45, then clear without accumulate, then restart from zero.
    acc_en = 1'b1; acc_clr = 1'b1;
    send(2'b00, 32'h0300_0000, 8'h05, 48'd15);
    acc_clr = 1'b0;
    send(2'b00, 32'h0300_0000, 8'h05, 48'd30);
    send(2'b00, 32'h0300_0000, 8'h05, 48'd45);
    acc_clr = 1'b1; acc_en = 1'b0;
    send(2'b00, 32'h0300_0000, 8'h05, 48'd15);
    acc_clr = 1'b0; acc_en = 1'b1;
    send(2'b00, 32'h0300_0000, 8'h05, 48'd15);
    idle(4);
    acc_en = 1'b0;
`endif

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_mult_block_pipe.md
MAC_MULT_BLOCK_PIPE -- requirements
Module: mac_mult_block_pipe

Interface
REQ-001: Parameter MIN_WIDTH, default 8: width of one lane operand.
REQ-002: Parameter ACC_GUARD, default 8: extra accumulator guard bits, used only when MAC_MULT_ACC_EN is defined.
REQ-003: Derived widths SHALL be fixed as follows: INT_WIDTH = 5*MIN_WIDTH; ACC_WIDTH = INT_WIDTH + ACC_GUARD.
REQ-004: clk  input  1  single clock; all state updates on the rising edge.
REQ-005: rst  input  1  asynchronous, active-low reset.
REQ-006: en  input  1  global enable; 0 freezes the pipeline.
REQ-007: in_valid  input  1  input transaction present.
REQ-008: in_ready  output  1  block accepts the input this cycle.
REQ-009: A  input  4*MIN_WIDTH  lanes A0 (LSBs) to A3 (MSBs).
REQ-010: B3  input  MIN_WIDTH  common multiplier.
REQ-011: cfg  input  2  mode: 2'b00 SINGLE, 2'b01 DUAL, 2'b10 QUAD, 2'b11 reserved.
REQ-012: out_valid  output  1  C holds a valid result.
REQ-013: out_ready  input  1  downstream accepts C.
REQ-014: C  output  INT_WIDTH (ACC_WIDTH with MAC_MULT_ACC_EN)  result.

Function
REQ-015: Partial products SHALL be Pi = Ai*B3 for i = 0..3, unsigned, each 2*MIN_WIDTH wide.
REQ-016: SINGLE mode: C = P3, zero-extended.
REQ-017: DUAL mode: C = P2 + (P3 << MIN_WIDTH).
REQ-018: QUAD mode: C = P0 + (P1 << W) + (P2 << 2W) + (P3 << 3W), where W = MIN_WIDTH.
REQ-019: Reserved cfg: the result SHALL be 0, and the transaction still flows through the pipeline with valid set.
REQ-020: cfg is sampled with its transaction; changing cfg SHALL NOT affect transactions already in flight.
REQ-021: The pipeline has 2 stages.
  - Stage 1 registers P0..P3, cfg and valid.
  - Stage 2 registers the summed result into C together with out_valid.
REQ-022: Advance condition: advance = en & (~out_valid | out_ready); in_ready = advance.
REQ-023: All stage registers SHALL load only when advance = 1; otherwise they hold.
REQ-024: A transfer occurs when in_valid & in_ready; the result SHALL appear on C with out_valid = 1 exactly 2 advancing cycles later.
REQ-025: Throughput SHALL be 1 transaction per cycle while en = 1 and out_ready = 1.
REQ-026: Bubbles: cycles with in_valid = 0 and advance = 1 SHALL propagate invalid stages; results SHALL never be duplicated, dropped or reordered.
REQ-027: C and out_valid SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-028: When en = 0, in_ready = 0 and all state SHALL be held, including an output awaiting out_ready.
REQ-029: Arithmetic SHALL be unsigned and exact in INT_WIDTH; no overflow is possible (max is (2^4W - 1)*(2^W - 1)).

Reset
REQ-030: While rst = 0, the block SHALL asynchronously clear stage-1 valid, out_valid, C, all partial-product registers and (when present) the accumulator to 0.
REQ-031: Reset asserted mid-operation SHALL discard all in-flight transactions; none SHALL emerge after release.
REQ-032: in_ready SHALL be 0 during reset, and advance may assert from the first clock edge after rst rises.

Configuration
REQ-033: Macro MAC_MULT_ACC_EN controls the accumulator feature.
  - Defined: ports acc_en (input, 1) and acc_clr (input, 1) are added and sampled with the transaction.
  - Defined: stage 2 keeps a register acc of ACC_WIDTH bits.
  - Defined: on each valid transaction leaving stage 1 under advance, acc <= (acc_clr ? 0 : acc) + (acc_en ? sum : 0), wrapping modulo 2^ACC_WIDTH.
  - Defined: C = the new acc value when acc_en = 1; otherwise C = sum, zero-extended.
  - Defined: acc_clr with acc_en = 0 clears acc, and C = sum.
  - Defined: bubbles leave acc unchanged.
REQ-034: Undefined: the acc_en/acc_clr ports and the acc register are absent, C is INT_WIDTH wide, and behaviour follows REQ-015..029 only.

Verification (MIN_WIDTH = 8)
REQ-035: SINGLE, A3 = 0xFF, B3 = 0xFF, one transfer -> out_valid rises 2 cycles later with C = 0xFE01.
REQ-036: Back-to-back transfers, out_ready = 1:
  - DUAL, A[31:16] = 0x1234, B3 = 0x10 -> C = 0x12340.
  - then QUAD, A = 0x12345678, B3 = 0x02 -> C = 0x2468ACF0 on the next cycle.
  - then cfg = 2'b11 -> C = 0.
REQ-037: Backpressure: 4 consecutive transfers with out_ready = 0 for 5 cycles -> in_ready drops once both stages are full, C is stable, and all 4 results emerge in order once out_ready = 1.
REQ-038: en = 0 for 3 cycles mid-stream -> in_ready = 0, no state change, and the stream resumes losslessly.
REQ-039: rst pulsed low with 2 transactions in flight -> out_valid = 0 and C = 0 immediately, and no stale result appears after release.
REQ-040: With MAC_MULT_ACC_EN, SINGLE mode with A3 = 3 and B3 = 5:
  - 3 transfers, acc_en = 1, first with acc_clr = 1 -> C = 15, 30, 45.
  - then acc_clr = 1, acc_en = 0 -> C = 15 and acc = 0.
